// File: rtl/arbitro_enrutamiento_param_if.sv
// VC-FIFO / destination-FIFO bundle for the arbiter/router.
// master = arbiter side, slave = FIFO side.
interface arbitro_enrutamiento_param_if #(
    parameter int DATA_W   = 6,
    parameter int NUM_VC   = 2,
    parameter int NUM_DEST = 2
);
    logic [NUM_VC*DATA_W-1:0]   vc_data;
    logic [NUM_VC-1:0]          vc_empty;
    logic [NUM_DEST-1:0]        dest_pause;
    logic [NUM_VC-1:0]          vc_pop;
    logic [NUM_DEST*DATA_W-1:0] dest_data;
    logic [NUM_DEST-1:0]        dest_push;
    logic                       err_bad_dest;

    modport master (
        input  vc_data,
        input  vc_empty,
        input  dest_pause,
        output vc_pop,
        output dest_data,
        output dest_push,
        output err_bad_dest
    );

    modport slave (
        output vc_data,
        output vc_empty,
        output dest_pause,
        input  vc_pop,
        input  dest_data,
        input  dest_push,
        input  err_bad_dest
    );
endinterface

// File: rtl/arbitro_enrutamiento_param.sv
// VC-to-destination arbiter/router, strict priority or round robin.
// Optional starvation aging in strict mode: define ARB_AGING_EN.
module arbitro_enrutamiento_param #(
    parameter int DATA_W    = 6,
    parameter int NUM_VC    = 2,
    parameter int NUM_DEST  = 2,
    parameter int DEST_LSB  = 4,
    parameter int RR_MODE   = 0,
    parameter int AGE_LIMIT = 8
) (
    input logic clk,
    input logic reset_L,
    arbitro_enrutamiento_param_if.master bus
);
    localparam int DW = $clog2(NUM_DEST);
    localparam int SW = $clog2(NUM_VC);

    if (DEST_LSB + DW > DATA_W || AGE_LIMIT < 1) begin : g_bad_cfg
        $error("arbitro_enrutamiento_param: bad parameters");
    end

    logic [NUM_VC-1:0]          req;
    logic                       pop_en;
    logic [SW-1:0]              grant;
    logic [SW-1:0]              rr_ptr;
    logic [SW-1:0]              sel_q;
    logic                       v1_q;
    logic [DATA_W-1:0]          word;
    logic [DW-1:0]              d;
    logic                       d_ok;
    logic [NUM_DEST-1:0]        push_q;
    logic [NUM_DEST*DATA_W-1:0] data_q;
    logic                       err_q;
    int                         rot;

    assign req    = ~bus.vc_empty;
    assign pop_en = reset_L && (|req) && !(|bus.dest_pause);

`ifdef ARB_AGING_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);

    logic [AW-1:0] age_q [NUM_VC];
    logic          starve_any;
    logic [SW-1:0] starve_idx;

    always_comb begin
        starve_any = 1'b0;
        starve_idx = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (req[k] && age_q[k] == AW'(AGE_LIMIT)) begin
                starve_any = 1'b1;
                starve_idx = SW'(k);
            end
        end
    end

    // counters only move on cycles where a grant is actually issued
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < NUM_VC; k++) age_q[k] <= '0;
        end else if (pop_en) begin
            for (int k = 0; k < NUM_VC; k++) begin
                if (grant == SW'(k))
                    age_q[k] <= '0;
                else if (req[k] && age_q[k] != AW'(AGE_LIMIT))
                    age_q[k] <= age_q[k] + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        rot   = 0;
        if (RR_MODE != 0) begin
            for (int k = NUM_VC - 1; k >= 0; k--) begin
                rot = (int'(rr_ptr) + k) % NUM_VC;
                if (req[rot]) grant = SW'(rot);
            end
        end else begin
            for (int k = NUM_VC - 1; k >= 0; k--) begin
                if (req[k]) grant = SW'(k);
            end
        end
`ifdef ARB_AGING_EN
        if (RR_MODE == 0 && starve_any) grant = starve_idx;
`endif
    end

    assign bus.vc_pop = pop_en ? (NUM_VC'(1) << grant) : '0;

    assign word = bus.vc_data[int'(sel_q) * DATA_W +: DATA_W];
    assign d    = word[DEST_LSB +: DW];
    assign d_ok = ({1'b0, d} < (DW + 1)'(NUM_DEST));

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr <= '0;
            sel_q  <= '0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= pop_en;
            if (pop_en) begin
                sel_q  <= grant;
                rr_ptr <= (grant == SW'(NUM_VC - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            push_q <= '0;
            err_q  <= v1_q && !d_ok;
            for (int i = 0; i < NUM_DEST; i++) begin
                if (v1_q && d_ok && d == DW'(i)) begin
                    push_q[i]                  <= 1'b1;
                    data_q[i*DATA_W +: DATA_W] <= word;
                end
            end
        end
    end

    assign bus.dest_push    = push_q;
    assign bus.dest_data    = data_q;
    assign bus.err_bad_dest = err_q;
endmodule
